// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture
// Purpose  : Drives the clock of an 8-bit parallel ADC and registers its
//            samples. On a threshold crossing (or a forced trigger) it stores
//            a fixed-length record of DEPTH samples in an internal buffer.
//            The record is then read back one sample per request.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_clk,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              force_trig,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Last buffer address: the write and read sequences both end here,
    // so the pointers never need to wrap.
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   s1_q;
    logic [DATA_W-1:0]   s2_q;
    logic [DATA_W-1:0]   lvl_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                busy_q;
    logic                done_q;

    // Record buffer; deliberately never cleared so it maps onto block RAM.
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                w_trig;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic                w_rd_en;

    // The ADC latches on its own rising edge, i.e. the sys_clk falling edge,
    // so its output is settled by the next sys_clk rising edge.
    assign adc_clk = ~sys_clk;

    // Rising crossing of the latched level between the two newest samples.
    // A level of zero can never be crossed, leaving only the forced trigger.
    assign w_trig = ((s2_q < lvl_q) && (s1_q >= lvl_q)) || force_trig;

    // Writes: the crossing sample goes to address 0, then one per cycle.
    assign w_wr_en   = ((state_q == ST_ARMED) && w_trig) || (state_q == ST_CAPTURE);
    assign w_wr_addr = (state_q == ST_ARMED) ? '0 : wr_ptr_q;

    // Reads are accepted only once a complete record is available.
    assign w_rd_en   = (state_q == ST_DONE) && rd_req;

    // Two-stage sample pipeline: s1 is the newest sample, s2 the one before.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= adc_data;
            s2_q <= s1_q;
        end
    end

    // Buffer write port.
    always_ff @(posedge sys_clk) begin
        if (w_wr_en) begin
            mem[w_wr_addr] <= s1_q;
        end
    end

    // Buffer read port; rd_data holds its value between accepted requests.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_data_q <= '0;
        end else if (w_rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Capture/readout sequencer with registered status outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            lvl_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        lvl_q   <= trig_level;
                        busy_q  <= 1'b1;
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        wr_ptr_q <= c_ADDR_ONE;
                        state_q  <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    wr_ptr_q <= wr_ptr_q + c_ADDR_ONE;
                    if (wr_ptr_q == c_LAST_ADDR) begin
                        rd_ptr_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rd_req) begin
                        rd_valid_q <= 1'b1;
                        rd_ptr_q   <= rd_ptr_q + c_ADDR_ONE;
                        if (rd_ptr_q == c_LAST_ADDR) begin
                            done_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture
// Purpose  : Self-checking bench for adc_capture (ADDR_W=4, 16-sample record)
//            with a queue-based behavioural model and directed stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture;

    localparam int DEPTH = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] adc_data = 8'h00;
    logic       adc_clk;
    logic       arm = 1'b0;
    logic [7:0] trig_level = 8'h00;
    logic       force_trig = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    adc_capture #(.DATA_W(8), .ADDR_W(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .adc_data   (adc_data),
        .adc_clk    (adc_clk),
        .arm        (arm),
        .trig_level (trig_level),
        .force_trig (force_trig),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;
    int m_mode = M_IDLE;
    int m_s1 = 0, m_s2 = 0, m_lvl = 0;
    int m_rd_data = 0;
    bit m_rd_valid = 0;
    int rec[$];

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_lvl = 0;
            m_rd_data = 0; m_rd_valid = 0;
            rec.delete();
        end else begin
            m_rd_valid = 0;
            case (m_mode)
                M_IDLE:  if (arm) begin m_lvl = int'(trig_level); m_mode = M_ARMED; end
                M_ARMED: if ((m_s2 < m_lvl && m_s1 >= m_lvl) || force_trig) begin
                             rec.delete(); rec.push_back(m_s1); m_mode = M_CAPT;
                         end
                M_CAPT:  begin
                             rec.push_back(m_s1);
                             if (rec.size() == DEPTH) m_mode = M_DONE;
                         end
                M_DONE:  if (rd_req) begin
                             m_rd_data = rec.pop_front(); m_rd_valid = 1;
                             if (rec.size() == 0) m_mode = M_IDLE;
                         end
                default: m_mode = M_IDLE;
            endcase
            m_s2 = m_s1;
            m_s1 = int'(adc_data);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge sys_clk) begin
        chk("busy",     {31'd0, busy},     {31'd0, (m_mode == M_ARMED || m_mode == M_CAPT)});
        chk("done",     {31'd0, done},     {31'd0, (m_mode == M_DONE)});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
        chk("rd_data",  {24'd0, rd_data},  m_rd_data);
    end

    // Collected read samples; done must fall together with the last one.
    int got[$];
    always @(negedge sys_clk) begin
        if (rd_valid === 1'b1) begin
            got.push_back(int'(rd_data));
            if (got.size() == DEPTH) chk("last_rd_done_low", {31'd0, done}, 0);
            else                     chk("mid_rd_done_high", {31'd0, done}, 1);
        end
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    // ---------------- stimulus sources ----------------
    localparam int SRC_RAMP = 0, SRC_CONST = 1, SRC_SAW = 2, SRC_DDS = 3;
    int src = SRC_CONST;
    int src_cnt = 0;
    int e80 = -1;
    int phase = 0;
    logic [7:0] d1 = 8'h00, d2 = 8'h00;
    logic [7:0] sine [16] = '{8'h80, 8'hB1, 8'hDA, 8'hF5, 8'hFF, 8'hF5, 8'hDA, 8'hB1,
                              8'h80, 8'h4F, 8'h26, 8'h0B, 8'h01, 8'h0B, 8'h26, 8'h4F};

    // Advance one cycle: inputs change just after the falling edge.
    task automatic step();
        @(negedge sys_clk);
        #1;
        src_cnt++;
        case (src)
            SRC_RAMP: begin
                adc_data = 8'(32'h70 + src_cnt);
                if (adc_data == 8'h80 && e80 < 0) e80 = cyc + 1;
            end
            SRC_CONST: adc_data = 8'h90;
            SRC_SAW:   adc_data = 8'(src_cnt * 16);
            default: begin
                d2 = d1;
                d1 = sine[phase];
                phase = (phase + 1) % 16;
                adc_data = d2;
            end
        endcase
    endtask

    task automatic pulse_arm(input logic [7:0] lvl);
        trig_level = lvl; arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin step(); n++; end
        chk(nm, {31'd0, done}, 1);
    endtask

    task automatic read_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            rd_req = 1'b1; step(); rd_req = 1'b0; step();
        end
    endtask

    task automatic read_held(input int n);
        rd_req = 1'b1;
        repeat (n) step();
        rd_req = 1'b0;
        step();
    endtask

    task automatic start_ramp();
        src = SRC_RAMP; src_cnt = -1; e80 = -1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rd_data"},  {24'd0, rd_data},  0);
        chk({nm, "_rd_valid"}, {31'd0, rd_valid}, 0);
        chk({nm, "_busy"},     {31'd0, busy},     0);
        chk({nm, "_done"},     {31'd0, done},     0);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        chk("adc_clk_in_reset", {31'd0, adc_clk}, {31'd0, ~sys_clk});
        sys_rst = 1'b0;
        step();
        chk("adc_clk_run", {31'd0, adc_clk}, {31'd0, ~sys_clk});

        // Ramp through 0x80; rd_req in IDLE/ARMED and arm in CAPTURE/DONE ignored
        start_ramp();
        rd_req = 1'b1;
        step();
        pulse_arm(8'h80);
        repeat (3) step();
        rd_req = 1'b0;
        chk("rd_ignored_armed", {31'd0, rd_valid}, 0);
        begin
            int n = 0;
            while ((e80 < 0 || cyc < e80 + 4) && n < 100) begin step(); n++; end
        end
        chk("busy_in_capture", {31'd0, busy}, 1);
        trig_level = 8'hFF; arm = 1'b1; step(); arm = 1'b0; trig_level = 8'h80;
        wait_done("ramp_done");
        chk("ramp_latency", cyc - e80, 16);
        got.delete();
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1'b1; step(); rd_req = 1'b0;
            if (i == 5) arm = 1'b1;
            step();
            arm = 1'b0;
        end
        chk("ramp_count", got.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < got.size(); i++)
            chk($sformatf("ramp_val%0d", i), got[i], 32'h80 + i);
        chk("ramp_idle_busy", {31'd0, busy}, 0);

        // No crossing on a constant level; force_trig completes it
        src = SRC_CONST;
        pulse_arm(8'h80);
        repeat (40) step();
        chk("const_busy", {31'd0, busy}, 1);
        chk("const_no_done", {31'd0, done}, 0);
        force_trig = 1'b1; step(); force_trig = 1'b0;
        wait_done("const_forced_done");
        got.delete();
        read_pulses(DEPTH);
        chk("const_count", got.size(), DEPTH);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("const_val%0d", i), got[i], 32'h90);

        // Level zero never triggers; back-to-back reads
        src = SRC_SAW; src_cnt = 0;
        pulse_arm(8'h00);
        repeat (40) step();
        chk("lvl0_no_done", {31'd0, done}, 0);
        chk("lvl0_busy", {31'd0, busy}, 1);
        force_trig = 1'b1; step(); force_trig = 1'b0;
        wait_done("lvl0_forced_done");
        got.delete();
        read_held(DEPTH);
        chk("b2b_count", got.size(), DEPTH);
        chk("b2b_idle_done", {31'd0, done}, 0);
        chk("b2b_idle_busy", {31'd0, busy}, 0);
        read_pulses(2);
        chk("rd_ignored_idle", got.size(), DEPTH);

        // Reset during capture (sample 5)
        start_ramp();
        pulse_arm(8'h80);
        begin
            int n = 0;
            while ((e80 < 0 || cyc < e80 + 6) && n < 100) begin step(); n++; end
        end
        #2 sys_rst = 1'b1;
        #1 chk_all_zero("rst_capture");
        step(); step();
        sys_rst = 1'b0;
        step();
        chk("rst_capture_idle", {31'd0, busy}, 0);

        // Reset during readout (after sample 3)
        start_ramp();
        pulse_arm(8'h80);
        wait_done("rst2_done");
        got.delete();
        read_pulses(3);
        chk("rst2_third", got.size() == 3 ? got[2] : -1, 32'h82);
        #2 sys_rst = 1'b1;
        #1 chk_all_zero("rst_readout");
        step();
        sys_rst = 1'b0;
        repeat (3) step();
        chk("rst_readout_novalid", got.size(), 3);

        // Fresh capture after reset
        start_ramp();
        pulse_arm(8'h80);
        wait_done("fresh_done");
        chk("fresh_latency", cyc - e80, 16);
        got.delete();
        read_pulses(DEPTH);
        chk("fresh_count", got.size(), DEPTH);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("fresh_val%0d", i), got[i], 32'h80 + i);

        // DDS loopback with two-cycle delay
        src = SRC_DDS; phase = 0; d1 = 8'h00; d2 = 8'h00;
        repeat (20) step();
        pulse_arm(8'h80);
        wait_done("dds_done");
        got.delete();
        read_held(DEPTH);
        chk("dds_count", got.size(), DEPTH);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("dds_val%0d", i), got[i], {24'd0, sine[i]});
        chk("dds_first", got.size() > 0 ? got[0] : -1, 32'h80);
        chk("dds_peak",  got.size() > 4 ? got[4] : -1, 32'hFF);
        chk("dds_trough", got.size() > 12 ? got[12] : -1, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adc_capture.md
# adc_capture

Receive-side counterpart of the DDS/DAC output path: drives the clock of an 8-bit parallel ADC and registers its samples. On a threshold crossing it stores a fixed-length record in an internal buffer, and the record is then read back one sample per request. It sits beside the DDS in the signal-generator top level, so a generated waveform can be looped back through DAC and ADC and checked.

## Interface
Parameters:
- DATA_W, 8, ADC sample width.
- ADDR_W, 8, buffer address width; record depth DEPTH = 2**ADDR_W.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- adc_data  in  DATA_W  parallel ADC output word.
- adc_clk  out  1  ADC sample clock, = ~sys_clk (combinational); the ADC updates on the sys_clk falling edge, so data is stable at the sys_clk rising edge.
- arm  in  1  one-cycle start pulse.
- trig_level  in  DATA_W  trigger threshold, latched on an accepted arm.
- force_trig  in  1  while ARMED, trigger unconditionally.
- rd_req  in  1  request next buffered sample.
- rd_data  out  DATA_W  read sample, registered.
- rd_valid  out  1  one-cycle qualifier for rd_data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE (record ready for readout).

## Operation
- Input pipeline:
  - s1 <= adc_data every cycle.
  - s2 <= s1 every cycle.
  - Both reset to 0.
- Trigger condition (unsigned): trig = (s2 < lvl) && (s1 >= lvl), or force_trig.
  - lvl is the latched trig_level.
- FSM states: IDLE, ARMED, CAPTURE, DONE. The FSM is registered and resets to IDLE.
- IDLE:
  - On arm: lvl <= trig_level, go to ARMED.
  - All other inputs are ignored.
- ARMED:
  - On trig: mem[0] <= s1, wr_ptr <= 1, go to CAPTURE.
  - arm is ignored.
- CAPTURE:
  - Each cycle: mem[wr_ptr] <= s1, wr_ptr++.
  - After writing address DEPTH-1, go to DONE with rd_ptr <= 0.
  - arm and force_trig are ignored.
- DONE:
  - On rd_req: rd_data <= mem[rd_ptr], rd_valid <= 1 on the next cycle, rd_ptr++.
  - The request that reads address DEPTH-1 moves the FSM to IDLE. Its rd_valid is still asserted.
  - Back-to-back rd_req are legal: one sample per cycle.
- rd_req outside DONE: ignored; rd_valid stays 0 and rd_data holds its value.
- lvl = 0: the crossing condition can never be met, so only force_trig starts a capture.
- lvl = max (all ones): triggers only when s1 = max and s2 < max.
- Pointer arithmetic is ADDR_W bits. Wrap is never used, because the state changes at DEPTH-1.
- Buffer contents are not cleared by reset or re-arm. Stale contents are never readable, because DONE is reached only after a full write.

## Timing
- Reset values:
  - rd_data = 0, rd_valid = 0, busy = 0, done = 0.
  - State = IDLE; s1, s2, lvl, wr_ptr, rd_ptr all 0.
  - adc_clk follows ~sys_clk even during reset.
- Reset asserted mid-capture or mid-readout: immediate return to IDLE. The partial record is abandoned and no rd_valid is produced.
- arm sampled at edge k: busy = 1 after edge k.
- Sample-to-buffer latency: adc_data present at edge n is in s1 after edge n and written at edge n+1.
- Trigger evaluated at edge t with s1 = crossing sample:
  - mem[0] = that sample, busy remains 1.
  - Addresses 1..DEPTH-1 are written at edges t+1..t+DEPTH-1.
  - At edge t+DEPTH-1: busy = 0, done = 1.
- Read latency: rd_req sampled at edge r gives rd_data/rd_valid valid after edge r, for exactly one cycle unless rd_req is held.
- On the final read: done = 0 after the same edge that asserts the last rd_valid.
- Buffer read is synchronous (inferred block RAM, single write port, single read port).

## Test plan
- Ramp and threshold (ADDR_W=4):
  - Stimulus: adc_data counts 0x70,0x71,… one step per cycle; arm with trig_level=0x80; then 16 rd_req pulses.
  - Expected: done asserts exactly 16 cycles after the 0x80 sample is first registered; reads return 0x80…0x8F in order; final rd_valid coincides with done falling.
- No crossing:
  - Stimulus: adc_data held at 0x90, trig_level=0x80, arm.
  - Expected: busy stays 1 indefinitely and done never rises.
  - Then pulse force_trig: capture completes with all samples = 0x90.
- Level zero and back-to-back reads:
  - Stimulus: trig_level=0x00, sawtooth input.
  - Expected: no trigger; force_trig required.
  - Then hold rd_req high for 16 cycles: 16 consecutive rd_valid pulses, no gaps, state IDLE afterwards.
- Ignored inputs:
  - Stimulus: rd_req in IDLE/ARMED; arm during CAPTURE and DONE.
  - Expected: rd_valid stays 0; capture length and lvl unchanged; extra arm in DONE does not restart the capture.
- Reset mid-operation:
  - Stimulus: assert sys_rst asynchronously (between edges) at capture sample 5, then again at readout sample 3.
  - Expected: all outputs read 0 immediately; state IDLE; a subsequent arm and trigger captures a fresh correct record.
- DDS loopback:
  - Stimulus: DDS sine output fed to adc_data with a 2-cycle delay model, trig_level=0x80.
  - Expected: the record starts at the first sample ≥0x80 after a sample <0x80, and the sample values match the DDS sequence.
